bus_arb: RTL
============

BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, bus-wait cycles before abort; used only when BUS_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  fetch stage read request, held until if_ready.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_rdata / if_ready  output  32 / 1  fetch read data / completion strobe.
REQ-007 mem_req, mem_we  input  1 each  mem stage request, write enable; held until mem_ready.
REQ-008 mem_addr, mem_wdata, mem_sel  input  32 / 32 / 4  mem stage address, write data, byte lanes.
REQ-009 mem_rdata / mem_ready  output  32 / 1  load data / completion strobe.
REQ-010 bus_req, bus_we, bus_addr, bus_wdata, bus_sel  output  1 / 1 / 32 / 32 / 4  registered shared-bus command.
REQ-011 bus_ack / bus_rdata  input  1 / 32  bus completion / read data.
REQ-012 stall  output  5  hold vector: [0] pc, [1] if_id, [2] id_ex, [3] ex_men, [4] men_wb.
REQ-013 bus_err  output  1  one-cycle timeout strobe.

Function
REQ-014 States: IDLE, BUSY_IF, BUSY_MEM.
REQ-015 IDLE with mem_req=1: latch mem command onto bus_* (bus_req=1), go to BUSY_MEM; mem wins over simultaneous if_req.
REQ-016 IDLE with if_req=1 and mem_req=0: latch bus_addr=if_addr, bus_we=0, bus_sel=4'hF, bus_wdata=0, bus_req=1, go to BUSY_IF.
REQ-017 BUSY_x with bus_ack=1: x_ready=1 combinationally that cycle, x_rdata=bus_rdata; at the clock edge bus_req<=0, state<=IDLE.
REQ-018 x_ready=0 and x_rdata=32'h0 in every other cycle.
REQ-019 Bus command fields stay constant while in BUSY_x; request withdrawal during BUSY_x is ignored and the transaction completes.
REQ-020 Minimum latency: request seen in IDLE at cycle N, bus_req high in N+1, earliest ready in N+1.
REQ-021 stall=5'b01111 when mem_req=1 and mem_ready=0; else 5'b00001 when if_req=1 and if_ready=0; else 5'b00000 (combinational).
REQ-022 A requester still asserted after another's completion is served from IDLE on the next cycle; no back-to-back issue without passing through IDLE.

Reset
REQ-023 rst=0 forces immediately: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_sel=0, bus_err=0, timeout counter=0.
REQ-024 Reset mid-transaction abandons it without a ready strobe; while rst=0, stall=0 and if_ready=mem_ready=0.

Configuration
REQ-025 With BUS_TIMEOUT_EN defined: counter clears on entry to BUSY_x, increments each BUSY cycle without bus_ack; when it reaches TIMEOUT_CYCLES-1 without ack, x_ready=1 with x_rdata=32'h0 and bus_err=1 for that cycle, then bus_req<=0, state<=IDLE.
REQ-026 With BUS_TIMEOUT_EN defined: bus_ack in the timeout cycle wins; normal completion, bus_err=0.
REQ-027 With BUS_TIMEOUT_EN undefined: no counter, bus_err tied 0, BUSY_x waits indefinitely.

Verification
REQ-028 if_req=1, if_addr=32'h100, bus_ack after 2 cycles with rdata 32'hDEADBEEF -> bus_addr=32'h100, bus_we=0, if_ready pulse with 32'hDEADBEEF, stall=5'b00001 until then.
REQ-029 if_req and mem_req (we=1, addr 32'h200, wdata 32'h55AA, sel 4'h3) same cycle -> mem issued first, stall=5'b01111; fetch issued the cycle after mem_ready.
REQ-030 mem load, bus_ack same cycle bus_req rises -> mem_ready in that cycle, IDLE next edge.
REQ-031 rst=0 asserted during BUSY_MEM -> bus_req=0 immediately, no mem_ready, stall=0.
REQ-032 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no bus_ack -> 4th BUSY cycle: bus_err=1, ready=1, rdata=0; ack coinciding with that cycle -> bus_err=0.

Source files
------------

// File: rtl/bus_arb_if.sv
// Handshake bundle between the fetch/mem stages, the shared bus and the arbiter.
// Ports: fetch req/addr/rdata/ready, mem req/we/addr/wdata/sel/rdata/ready,
//        bus req/we/addr/wdata/sel/ack/rdata, stall vector, bus_err strobe.
//        master = arbiter view, slave = pipeline/bus environment view.
interface bus_arb_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic [4:0]  stall;
    logic        bus_err;

    modport master (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        input  bus_ack, bus_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        output stall, bus_err
    );

    modport slave (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        output bus_ack, bus_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        input  stall, bus_err
    );
endinterface

// File: rtl/bus_arb.sv
// Shared-bus arbiter: mem stage wins over fetch, one registered bus command
// at a time, combinational ready/stall. Ports: clk, rst (async, active-low),
// arb (bus_arb_if.master). Optional BUS_TIMEOUT_EN aborts a bus wait after
// TIMEOUT_CYCLES busy cycles with a one-cycle bus_err strobe.
module bus_arb #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    bus_arb_if.master   arb
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    state_t      state, nxt_state;
    logic        nxt_req, nxt_we;
    logic [31:0] nxt_addr, nxt_wdata;
    logic [3:0]  nxt_sel;
    logic        busy, done, tmo;

    assign busy = (state != IDLE);

`ifdef BUS_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt;

    // Held at zero in IDLE, so each transaction starts counting from 0.
    assign tmo = busy && !arb.bus_ack && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (!busy)
            cnt <= '0;
        else if (!arb.bus_ack)
            cnt <= cnt + CW'(1);
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo = 1'b0;
`endif

    assign arb.bus_err = tmo;
    assign done = busy && (arb.bus_ack || tmo);

    // Timeout completes with zero data; only a real ack forwards bus_rdata.
    assign arb.if_ready  = done && (state == BUSY_IF);
    assign arb.mem_ready = done && (state == BUSY_MEM);
    assign arb.if_rdata  = (state == BUSY_IF && arb.bus_ack) ?
                           arb.bus_rdata : 32'h0;
    assign arb.mem_rdata = (state == BUSY_MEM && arb.bus_ack) ?
                           arb.bus_rdata : 32'h0;

    always_comb begin
        arb.stall = 5'b00000;
        if (rst) begin
            if (arb.mem_req && !arb.mem_ready)
                arb.stall = 5'b01111;
            else if (arb.if_req && !arb.if_ready)
                arb.stall = 5'b00001;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_req   = arb.bus_req;
        nxt_we    = arb.bus_we;
        nxt_addr  = arb.bus_addr;
        nxt_wdata = arb.bus_wdata;
        nxt_sel   = arb.bus_sel;
        unique case (state)
            IDLE: begin
                if (arb.mem_req) begin
                    nxt_state = BUSY_MEM;
                    nxt_req   = 1'b1;
                    nxt_we    = arb.mem_we;
                    nxt_addr  = arb.mem_addr;
                    nxt_wdata = arb.mem_wdata;
                    nxt_sel   = arb.mem_sel;
                end else if (arb.if_req) begin
                    nxt_state = BUSY_IF;
                    nxt_req   = 1'b1;
                    nxt_we    = 1'b0;
                    nxt_addr  = arb.if_addr;
                    nxt_wdata = 32'h0;
                    nxt_sel   = 4'hF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (done) begin
                    nxt_state = IDLE;
                    nxt_req   = 1'b0;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_req   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            arb.bus_req   <= 1'b0;
            arb.bus_we    <= 1'b0;
            arb.bus_addr  <= 32'h0;
            arb.bus_wdata <= 32'h0;
            arb.bus_sel   <= 4'h0;
        end else begin
            state         <= nxt_state;
            arb.bus_req   <= nxt_req;
            arb.bus_we    <= nxt_we;
            arb.bus_addr  <= nxt_addr;
            arb.bus_wdata <= nxt_wdata;
            arb.bus_sel   <= nxt_sel;
        end
    end

endmodule
